dispatch_queue: RTL

- Parametrised successor of the single-entry dispatcher. Buffers decoded instructions in a DEPTH-entry in-order queue and routes the head entry to one of NUM_UNITS execution-unit channels via valid/ready handshakes.
- Each dispatched instruction gets a wrapping RS_ID tag.
- Sits between the decoder and the execution units (add/sub, mul, div, log, rot, cmp, sys, trap, ...).
- Supports a synchronous pipeline flush.

---
 rtl/dispatch_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch queue routing its head entry to one of NUM_UNITS execution units
//
// Purpose:
//   Buffers decoded instructions in a DEPTH-entry FIFO. The head entry is offered
//   to the unit named by its select field, and each accepted dispatch takes the next
//   value of a wrapping RS_ID tag. A head entry with an out-of-range select is
//   dropped without using a tag, and sel_error pulses for one cycle.
//
// Optional feature:
//   DISPATCH_STALL_COUNT_EN - adds the 32-bit saturating stall_count output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard every queued entry (the tag counter is kept)
//   input_valid/ready   decoder handshake; input_unit_sel, input_payload = entry
//   unit_valid          one-hot offer of the head entry to unit i
//   unit_ready          per-unit accept; only the selected bit is used
//   unit_payload        head payload, shared by all units
//   unit_tag            tag the head entry gets if it is accepted
//   sel_error           one-cycle pulse after an illegal-select entry is dropped
//   occupancy           current entry count
//   stall_count         (optional) cycles the legal head waited on its unit
module dispatch_queue #(
    parameter int RS_ID_WIDTH   = 5,
    parameter int NUM_UNITS     = 8,
    parameter int DEPTH         = 4,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int SEL_WIDTH     = $clog2(NUM_UNITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic [SEL_WIDTH-1:0]     input_unit_sel,
    input  logic [PAYLOAD_WIDTH-1:0] input_payload,
    output logic [NUM_UNITS-1:0]     unit_valid,
    input  logic [NUM_UNITS-1:0]     unit_ready,
    output logic [PAYLOAD_WIDTH-1:0] unit_payload,
    output logic [RS_ID_WIDTH-1:0]   unit_tag,
    output logic                     sel_error,
`ifdef DISPATCH_STALL_COUNT_EN
    output logic [31:0]              stall_count,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [SEL_WIDTH:0] NUM_UNITS_W = (SEL_WIDTH + 1)'(NUM_UNITS);

    logic [SEL_WIDTH-1:0]     sel_mem_q [DEPTH];
    logic [SEL_WIDTH-1:0]     sel_mem_d [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] pay_mem_q [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] pay_mem_d [DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [RS_ID_WIDTH-1:0] tag_q, tag_d;
    logic                   sel_error_q, sel_error_d;

    logic [SEL_WIDTH-1:0] head_sel;
    logic                 head_valid;
    logic                 head_legal;
    logic                 push;
    logic                 pop;
    logic                 drop;

    assign head_sel   = sel_mem_q[rd_ptr_q];
    assign head_valid = (occ_q != '0);
    assign head_legal = head_valid && ({1'b0, head_sel} < NUM_UNITS_W);

    // Ready depends on registered occupancy only: a full queue never takes a
    // new entry, even in a cycle where the head leaves.
    assign input_ready = (occ_q != OCC_W'(DEPTH));
    assign push        = input_valid && input_ready;

    always_comb begin
        unit_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_valid[i] = head_legal && (head_sel == SEL_WIDTH'(i));
        end
    end

    // unit_valid is one-hot, so masking with unit_ready picks out the selected
    // unit's ready and ignores the rest.
    assign pop  = |(unit_valid & unit_ready);
    assign drop = head_valid && !head_legal;

    assign unit_payload = pay_mem_q[rd_ptr_q];
    assign unit_tag     = tag_q;
    assign sel_error    = sel_error_q;
    assign occupancy    = occ_q;

    always_comb begin
        sel_mem_d   = sel_mem_q;
        pay_mem_d   = pay_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        tag_d       = tag_q;
        sel_error_d = 1'b0;

        if (flush) begin
            // Same-cycle push, pop and drop are all discarded; tag_q is kept so
            // tags still in flight downstream stay unique.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                sel_mem_d[wr_ptr_q] = input_unit_sel;
                pay_mem_d[wr_ptr_q] = input_payload;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop || drop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                tag_d = tag_q + RS_ID_WIDTH'(1);
            end
            sel_error_d = drop;
            case ({push, pop || drop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            tag_q       <= '0;
            sel_error_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            tag_q       <= tag_d;
            sel_error_q <= sel_error_d;
        end
    end

    // Entry storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        sel_mem_q <= sel_mem_d;
        pay_mem_q <= pay_mem_d;
    end

`ifdef DISPATCH_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // A legal head that is not popped is waiting on its unit's ready. Counting
    // continues through flush cycles and the counter is never cleared by flush.
    always_comb begin
        stall_count_d = stall_count_q;
        if (head_legal && !pop && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    // No stall counter in this build.
`endif

endmodule
